// File: rtl/mlp_ctrl_pkg.sv
// Shared types for the MLP layer control path: FSM state encoding and default index width.
// Pure declarations; no timing or flow-control behaviour.
package mlp_ctrl_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   localparam int IDX_W_DEF = 7;

endpackage

// File: rtl/nested_loop_counter_if.sv
// Control/status bundle between the layer controller and the nested loop counter.
// Master drives start/abort/en and the end counts; slave returns indices, last flags, busy and done.
interface nested_loop_counter_if
   import mlp_ctrl_pkg::*;
#(
   parameter int IW = IDX_W_DEF,
   parameter int OW = IDX_W_DEF
);

   logic          start;
   logic          abort;
   logic          en;
   logic [IW-1:0] inner_end;
   logic [OW-1:0] outer_end;
   logic          busy;
   logic [IW-1:0] inner_idx;
   logic [OW-1:0] outer_idx;
   logic          inner_last;
   logic          outer_last;
   logic          done;

   modport master (
      output start, abort, en, inner_end, outer_end,
      input  busy, inner_idx, outer_idx, inner_last, outer_last, done
   );

   modport slave (
      input  start, abort, en, inner_end, outer_end,
      output busy, inner_idx, outer_idx, inner_last, outer_last, done
   );

endinterface

// File: rtl/loop_level_cnt.sv
// One loop level: latched end count, registered index and last flag; index, last and end update on the edge after load/step.
// hold freezes the level on a step so the final pair survives the end of a sweep; wrap_step cascades into the next level.
module loop_level_cnt
   import mlp_ctrl_pkg::*;
#(
   parameter int W = IDX_W_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         step,
   input  logic         hold,
   input  logic [W-1:0] end_val,
   output logic [W-1:0] idx,
   output logic         last,
   output logic         wrap_step
);

   logic [W-1:0] end_q, end_d;
   logic [W-1:0] idx_q, idx_d;
   logic         last_q, last_d;
   logic [W-1:0] idx_inc;

   // Only taken when idx_q is below end_q, so it cannot overflow even for an all-ones end.
   assign idx_inc = idx_q + W'(1);

   always_comb begin
      end_d  = end_q;
      idx_d  = idx_q;
      last_d = last_q;
      if (load) begin
         end_d  = end_val;
         idx_d  = '0;
         last_d = (end_val == '0);
      end else if (step && !hold) begin
         if (last_q) begin
            idx_d  = '0;
            last_d = (end_q == '0);
         end else begin
            idx_d  = idx_inc;
            last_d = (idx_inc == end_q);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         end_q  <= '0;
         idx_q  <= '0;
         last_q <= 1'b0;
      end else begin
         end_q  <= end_d;
         idx_q  <= idx_d;
         last_q <= last_d;
      end
   end

   assign idx       = idx_q;
   assign last      = last_q;
   assign wrap_step = step & last_q;

endmodule

// File: rtl/nested_loop_counter.sv
// Two-level (outer, inner) index sequencer with start/busy/done; pair (0,0) is valid the edge after start, one pair per busy&en edge.
// en low stalls indefinitely with all outputs held; abort returns to idle without done.
module nested_loop_counter
   import mlp_ctrl_pkg::*;
#(
   parameter int IW = IDX_W_DEF,
   parameter int OW = IDX_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   nested_loop_counter_if.slave  bus
);

   state_e        state_q, state_d;
   logic          done_q, done_d;

   logic          load;
   logic          run_step;
   logic          final_pair;
   logic          inner_wrap;
   logic          outer_wrap;
   logic [IW-1:0] inner_idx;
   logic [OW-1:0] outer_idx;
   logic          inner_last;
   logic          outer_last;

   assign load       = (state_q == ST_IDLE) & bus.start;
   assign run_step   = (state_q == ST_RUN) & bus.en & ~bus.abort;
   assign final_pair = inner_last & outer_last;

   loop_level_cnt #(.W(IW)) u_inner (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .step      (run_step),
      .hold      (final_pair),
      .end_val   (bus.inner_end),
      .idx       (inner_idx),
      .last      (inner_last),
      .wrap_step (inner_wrap)
   );

   // The outer level advances only when the inner level wraps.
   loop_level_cnt #(.W(OW)) u_outer (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .step      (inner_wrap),
      .hold      (final_pair),
      .end_val   (bus.outer_end),
      .idx       (outer_idx),
      .last      (outer_last),
      .wrap_step (outer_wrap)
   );

   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.start) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (bus.abort) begin
               state_d = ST_IDLE;
            end else if (outer_wrap) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
      end
   end

   assign bus.busy       = (state_q == ST_RUN);
   assign bus.done       = done_q;
   assign bus.inner_idx  = inner_idx;
   assign bus.outer_idx  = outer_idx;
   assign bus.inner_last = inner_last;
   assign bus.outer_last = outer_last;

endmodule
